// File: rtl/sb_mixer_lo_ctrl.sv
// Quadrature LO generator for a switching mixer with serial configuration and optional divider sweep.
// Define SBMIX_SWEEP_EN to build the SWEEP/DONE states and the DIV_END/DWELL registers.
module sb_mixer_lo_ctrl (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic cfg_sclk,
  input  logic cfg_sdi,
  input  logic cfg_csn,
  output logic lo_i,
  output logic lo_q,
  output logic lo_en,
  output logic busy,
  output logic sweep_done
);

  localparam logic [3:0] A_DIV_START = 4'd0;
  localparam logic [3:0] A_CTRL      = 4'd3;
`ifdef SBMIX_SWEEP_EN
  localparam logic [3:0] A_DIV_END   = 4'd1;
  localparam logic [3:0] A_DWELL     = 4'd2;

  typedef enum logic [1:0] {IDLE, RUN, SWEEP, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  // Reset asserts asynchronously everywhere but releases on a clock edge.
  logic [1:0] rst_sy;
  logic       rst_ni;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sy <= 2'b00;
    else        rst_sy <= {rst_sy[0], 1'b1};
  end

  assign rst_ni = rst_sy[1];

  // ---- serial port: synchronizers, edge detect, shifter
  logic [2:0]  sclk_sy;
  logic [1:0]  sdi_sy;
  logic [2:0]  csn_sy;
  logic        sclk_rise;
  logic        csn_rise;
  logic        csn_s;
  logic [4:0]  bit_cnt;
  logic        frame_wr;
  logic [15:0] shreg;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_sy <= 3'b000;
      sdi_sy  <= 2'b00;
      csn_sy  <= 3'b111;
    end else begin
      sclk_sy <= {sclk_sy[1:0], cfg_sclk};
      sdi_sy  <= {sdi_sy[0], cfg_sdi};
      csn_sy  <= {csn_sy[1:0], cfg_csn};
    end
  end

  assign csn_s     = csn_sy[1];
  assign sclk_rise = sclk_sy[1] & ~sclk_sy[2];
  assign csn_rise  = csn_sy[1] & ~csn_sy[2];

  // Bit counter saturates above 16 so over-long frames are rejected too.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt  <= '0;
      frame_wr <= 1'b0;
    end else begin
      frame_wr <= csn_rise && (bit_cnt == 5'd16);
      if (csn_s)
        bit_cnt <= '0;
      else if (sclk_rise && (bit_cnt < 5'd17))
        bit_cnt <= bit_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!csn_s && sclk_rise)
      shreg <= {shreg[14:0], sdi_sy[1]};
  end

  logic [3:0]  wr_addr;
  logic [11:0] wr_data;
  logic        ctrl_wr;
  logic        run_bit;

  assign wr_addr = shreg[15:12];
  assign wr_data = shreg[11:0];
  assign ctrl_wr = frame_wr && (wr_addr == A_CTRL);
  assign run_bit = wr_data[0];

  // ---- configuration registers
  logic [11:0] div_start;
`ifdef SBMIX_SWEEP_EN
  logic [11:0] div_end;
  logic [11:0] dwell;
  logic        sweep_bit;
  logic        unused_data;

  assign sweep_bit   = wr_data[1];
  assign unused_data = ^wr_data[11:2];

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      div_start <= '0;
      div_end   <= '0;
      dwell     <= '0;
    end else if (frame_wr) begin
      if (wr_addr == A_DIV_START) div_start <= wr_data;
      if (wr_addr == A_DIV_END)   div_end   <= wr_data;
      if (wr_addr == A_DWELL)     dwell     <= wr_data;
    end
  end
`else
  logic unused_data;

  assign unused_data = ^wr_data[11:1];

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni)
      div_start <= '0;
    else if (frame_wr && (wr_addr == A_DIV_START))
      div_start <= wr_data;
  end
`endif

  // ---- phase generator and control FSM
  function automatic logic lo_i_of(input logic [1:0] p);
    return ~p[1];
  endfunction

  function automatic logic lo_q_of(input logic [1:0] p);
    return p[1] ^ p[0];
  endfunction

  state_t      state;
  logic [11:0] div;
  logic [11:0] div_nxt;
  logic [11:0] cnt;
  logic [1:0]  phase;
  logic        active;
  logic        tick;
  logic [11:0] div_rearm;

  assign tick = (cnt == div);

  // A CTRL run write landing exactly on the wrap still retunes at that wrap.
  assign div_rearm = (ctrl_wr && run_bit && (state == RUN)) ? div_start : div_nxt;

`ifdef SBMIX_SWEEP_EN
  logic [11:0] dwl_cnt;
  logic        dwl_last;
  logic        sweep_done_r;

  assign active     = (state == RUN) || (state == SWEEP);
  assign dwl_last   = ({1'b0, dwl_cnt} + 13'd1) >= {1'b0, dwell};
  assign sweep_done = sweep_done_r;
`else
  assign active     = (state == RUN);
  assign sweep_done = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      div     <= '0;
      div_nxt <= '0;
      cnt     <= '0;
      phase   <= '0;
      lo_i    <= 1'b0;
      lo_q    <= 1'b0;
      lo_en   <= 1'b0;
      busy    <= 1'b0;
`ifdef SBMIX_SWEEP_EN
      dwl_cnt      <= '0;
      sweep_done_r <= 1'b0;
`endif
    end else begin
      if (active) begin
        lo_en <= ena;
        busy  <= 1'b1;
        if (ena) begin
          if (tick) begin
            cnt   <= '0;
            phase <= phase + 2'd1;
            lo_i  <= lo_i_of(phase + 2'd1);
            lo_q  <= lo_q_of(phase + 2'd1);
            // Divider changes only on the p3->p0 wrap, never mid-period.
            if (phase == 2'd3) begin
`ifdef SBMIX_SWEEP_EN
              if (state == SWEEP) begin
                if (dwl_last) begin
                  dwl_cnt <= '0;
                  if (div == div_end) begin
                    state        <= DONE;
                    lo_en        <= 1'b0;
                    busy         <= 1'b0;
                    sweep_done_r <= 1'b1;
                    lo_i         <= 1'b1;
                    lo_q         <= 1'b0;
                  end else if (div < div_end) begin
                    div <= div + 12'd1;
                  end else begin
                    div <= div - 12'd1;
                  end
                end else begin
                  dwl_cnt <= dwl_cnt + 12'd1;
                end
              end else
`endif
                div <= div_rearm;
            end
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
      end

      if (ctrl_wr) begin
`ifdef SBMIX_SWEEP_EN
        sweep_done_r <= 1'b0;
        if (!run_bit || (state == DONE)) begin
`else
        if (!run_bit) begin
`endif
          state <= IDLE;
          lo_i  <= 1'b0;
          lo_q  <= 1'b0;
          lo_en <= 1'b0;
          busy  <= 1'b0;
        end else if (state == IDLE) begin
`ifdef SBMIX_SWEEP_EN
          state   <= sweep_bit ? SWEEP : RUN;
          dwl_cnt <= '0;
`else
          state   <= RUN;
`endif
          div     <= div_start;
          div_nxt <= div_start;
          cnt     <= '0;
          phase   <= '0;
          lo_i    <= 1'b1;
          lo_q    <= 1'b0;
          lo_en   <= ena;
          busy    <= 1'b1;
        end else if (state == RUN) begin
          div_nxt <= div_start;
        end
      end
    end
  end

endmodule

// File: tb/tb_sb_mixer_lo_ctrl.sv
// Directed bench for sb_mixer_lo_ctrl: serial frames in, LO edge timing and status flags out.
// Sweep scenarios are included when SBMIX_SWEEP_EN is defined, the run-only scenarios otherwise.
module tb_sb_mixer_lo_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic cfg_sclk = 1'b0;
  logic cfg_sdi = 1'b0;
  logic cfg_csn = 1'b1;
  logic lo_i, lo_q, lo_en, busy, sweep_done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rises[$];
  int q_rises[$];
  logic lo_i_d = 1'b0;
  logic lo_q_d = 1'b0;
  logic mon_run = 1'b0;
  logic seg_ok = 1'b0;
  int run_len = 0;
  int min_run = 1000;
  int odd_per;

  sb_mixer_lo_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .cfg_sclk   (cfg_sclk),
    .cfg_sdi    (cfg_sdi),
    .cfg_csn    (cfg_csn),
    .lo_i       (lo_i),
    .lo_q       (lo_q),
    .lo_en      (lo_en),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Edge log and shortest-pulse tracker, sampled on the falling edge.
  always @(negedge clk) begin
    if (lo_i === 1'b1 && lo_i_d === 1'b0) rises.push_back(cyc);
    if (lo_q === 1'b1 && lo_q_d === 1'b0) q_rises.push_back(cyc);
    if (mon_run) begin
      if (lo_i !== lo_i_d) begin
        if (seg_ok && run_len < min_run) min_run = run_len;
        seg_ok = 1'b1;
        run_len = 1;
      end else begin
        run_len++;
      end
    end
    lo_i_d = lo_i;
    lo_q_d = lo_q;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int per(input int k);
    if (k > 0 && rises.size() > k) return rises[k] - rises[k-1];
    return -1;
  endfunction

  function automatic int last_per();
    int n;
    n = rises.size();
    if (n < 2) return -1;
    return rises[n-1] - rises[n-2];
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [15:0] w, input int nbits);
    cfg_csn = 1'b0;
    wait_cyc(3);
    for (int i = 0; i < nbits; i++) begin
      cfg_sdi = w[15-i];
      wait_cyc(3);
      cfg_sclk = 1'b1;
      wait_cyc(3);
      cfg_sclk = 1'b0;
    end
    wait_cyc(3);
    cfg_csn = 1'b1;
    wait_cyc(8);
  endtask

  task automatic wr(input logic [3:0] a, input logic [11:0] d);
    send_bits({a, d}, 16);
  endtask

  task automatic check_periods(input string tag, input int p1, input int p2, input int p3,
                               input int p4, input int p5, input int p6);
    check_eq({tag, "_p1"}, per(1), p1);
    check_eq({tag, "_p2"}, per(2), p2);
    check_eq({tag, "_p3"}, per(3), p3);
    check_eq({tag, "_p4"}, per(4), p4);
    check_eq({tag, "_p5"}, per(5), p5);
    check_eq({tag, "_p6"}, per(6), p6);
  endtask

  initial begin
    ena   = 1'b1;
    rst_n = 1'b0;
    wait_cyc(3);
    check_eq("rst_outs", {lo_i, lo_q, lo_en, busy, sweep_done}, 0);
    rst_n = 1'b1;
    wait_cyc(6);
    check_eq("idle_outs", {lo_i, lo_q, lo_en, busy, sweep_done}, 0);

    // Fixed LO at div=3
    wr(4'd0, 12'd3);
    check_eq("idle_after_cfg", busy, 0);
    rises.delete();
    q_rises.delete();
    wr(4'd3, 12'h001);
    wait_cyc(40);
    check_eq("run_lo_en", lo_en, 1);
    check_eq("run_busy", busy, 1);
    check_eq("fixed_p1", per(1), 16);
    check_eq("fixed_p2", per(2), 16);
    check_eq("q_lag", (q_rises.size() > 0 && rises.size() > 0) ? q_rises[0] - rises[0] : -1, 4);

    // Register write alone does not retune
    wr(4'd0, 12'd0);
    rises.delete();
    wait_cyc(40);
    check_eq("no_retune", per(1), 16);

    // Retune via CTRL: old period completes, then 4-clk periods
    rises.delete();
    seg_ok = 1'b0;
    run_len = 0;
    min_run = 1000;
    mon_run = 1'b1;
    wr(4'd3, 12'h001);
    wait_cyc(30);
    mon_run = 1'b0;
    odd_per = 0;
    for (int k = 1; k < rises.size(); k++)
      if (rises[k] - rises[k-1] != 4 && rises[k] - rises[k-1] != 16) odd_per++;
    check_eq("retune_first", per(1), 16);
    check_eq("retune_last", last_per(), 4);
    check_eq("retune_odd", odd_per, 0);
    check_eq("retune_min_run", min_run, 2);

    // 15-bit frame is discarded; the next full frame is accepted
    wr(4'hF, 12'h000);
    send_bits(16'h000A, 15);
    wr(4'd3, 12'h001);
    rises.delete();
    wait_cyc(30);
    check_eq("bad_frame", last_per(), 4);
    wr(4'd0, 12'd1);
    wr(4'd3, 12'h001);
    rises.delete();
    wait_cyc(40);
    check_eq("good_frame", last_per(), 8);

    // ena low freezes the LO and drops lo_en
    ena = 1'b0;
    wait_cyc(2);
    check_eq("ena_lo_en", lo_en, 0);
    check_eq("ena_busy", busy, 1);
    rises.delete();
    wait_cyc(20);
    check_eq("ena_hold", rises.size(), 0);
    ena = 1'b1;
    wait_cyc(2);
    check_eq("ena_back", lo_en, 1);

    // CTRL run=0 returns to IDLE
    wr(4'd3, 12'h000);
    check_eq("stop_outs", {lo_i, lo_q, lo_en, busy}, 0);

`ifdef SBMIX_SWEEP_EN
    // Up-sweep 2 -> 4, two periods per step
    wr(4'd0, 12'd2);
    wr(4'd1, 12'd4);
    wr(4'd2, 12'd2);
    rises.delete();
    wr(4'd3, 12'h003);
    wait_cyc(130);
    check_periods("up", 12, 12, 16, 16, 20, 20);
    check_eq("up_done", {sweep_done, lo_en, busy, lo_i, lo_q}, 5'b10010);
    wr(4'd3, 12'h000);
    check_eq("done_clear", sweep_done, 0);

    // Down-sweep 4 -> 2
    wr(4'd0, 12'd4);
    wr(4'd1, 12'd2);
    rises.delete();
    wr(4'd3, 12'h003);
    wait_cyc(130);
    check_periods("down", 20, 20, 16, 16, 12, 12);
    check_eq("down_done", sweep_done, 1);
    wr(4'd3, 12'h000);

    // Reset in the middle of the second step
    wr(4'd0, 12'd2);
    wr(4'd1, 12'd4);
    wr(4'd3, 12'h003);
    wait_cyc(30);
    check_eq("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 check_eq("async_rst", {lo_i, lo_q, lo_en, busy, sweep_done}, 0);
    wait_cyc(3);
    rst_n = 1'b1;
    rises.delete();
    wait_cyc(60);
    check_eq("post_rst_idle", {busy, lo_en}, 0);
    check_eq("post_rst_quiet", rises.size(), 0);
    wr(4'd3, 12'h003);
    wait_cyc(20);
    check_eq("post_rst_sweep_p1", per(1), 4);
    check_eq("post_rst_done", {sweep_done, busy}, 2'b10);
`else
    // Sweep request without sweep support runs at DIV_START
    wr(4'd0, 12'd2);
    wr(4'd1, 12'd5);
    wr(4'd2, 12'd1);
    rises.delete();
    wr(4'd3, 12'h003);
    wait_cyc(60);
    check_eq("nosw_busy", busy, 1);
    check_eq("nosw_lo_en", lo_en, 1);
    check_eq("nosw_p1", per(1), 12);
    check_eq("nosw_p2", per(2), 12);
    wait_cyc(200);
    check_eq("nosw_done", sweep_done, 0);
    check_eq("nosw_still_run", busy, 1);

    // Reset while running
    #2 rst_n = 1'b0;
    #1 check_eq("async_rst", {lo_i, lo_q, lo_en, busy, sweep_done}, 0);
    wait_cyc(3);
    rst_n = 1'b1;
    rises.delete();
    wait_cyc(60);
    check_eq("post_rst_idle", {busy, lo_en}, 0);
    check_eq("post_rst_quiet", rises.size(), 0);
    wr(4'd3, 12'h001);
    wait_cyc(20);
    check_eq("post_rst_p1", per(1), 4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
